down_counter_timer: RTL

- Programmable countdown timer. It is the complementary direction to the free-running up_counter in the same design.
- It loads a terminal value through a valid/ready handshake and decrements to zero on command.
- At zero it emits a one-cycle terminal-count pulse, then either stops or auto-reloads.
- It is used as a timeout and period generator beside up_counter-based event counters.

---
 rtl/down_counter_timer_pkg.sv | 13 +
 rtl/down_counter_timer_tick_prescaler.sv | 36 +++
 rtl/down_counter_timer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_pkg.sv
// rtl/down_counter_timer_pkg.sv - shared types and constants for the countdown timer
package down_counter_timer_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/down_counter_timer_tick_prescaler.sv
// rtl/down_counter_timer_tick_prescaler.sv - divides clk into a one-cycle tick every PRESCALE clocks
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Gated by clear so the first tick after RUN entry lands a full period later.
    assign tick = !clear && (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable countdown timer with terminal-count pulse and auto-reload
// Optional prescaled counting is enabled by defining DOWN_COUNTER_TIMER_PRESCALE_EN.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int DEFAULT_LOAD = 20
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
    ,
    parameter int PRESCALE     = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter_down,
    output logic             tc_pulse,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             tc_q;
    logic             tc_d;
    logic             load_xfer;
    logic [WIDTH-1:0] eff_count;
    logic             eff_zero;
    logic             tick;

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state_q != RUN),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign load_xfer = load_valid && load_ready;

    // Value that IDLE/DONE would commit this edge: a fresh load wins, then a restart from DONE.
    always_comb begin
        eff_count = count_q;
        if (load_xfer) begin
            eff_count = load_value;
        end else if ((state_q == DONE) && start) begin
            eff_count = reload_q;
        end
    end

    assign eff_zero = (eff_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = eff_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (pause) begin
                    state_d = PAUSED;
                end else if ((count_q == '0) && !auto_reload) begin
                    state_d = DONE;
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                count_d = eff_count;
                if (load_xfer) begin
                    reload_d = load_value;
                end
                tc_d = start && eff_zero;
            end
            RUN: begin
                if (!pause && tick) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (count_q == WIDTH'(1)) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else if (auto_reload) begin
                        count_d = reload_q;
                    end
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= WIDTH'(DEFAULT_LOAD);
            reload_q <= WIDTH'(DEFAULT_LOAD);
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        busy       = (state_q == RUN) || (state_q == PAUSED);
        load_ready = (state_q == IDLE) || (state_q == DONE);
    end

    assign counter_down = count_q;
    assign tc_pulse     = tc_q;

endmodule
